mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory stage of the 5-stage RV32I pipeline.
package mem_pkg;

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_UJ  = 2'b11;

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and sign/zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {{24{1'b0}}, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {{16{1'b0}}, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the req/ack data bus, stalls the front of the pipe while a
// transfer is outstanding, and registers the MEM/WB boundary.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TOWIDTH = 8,
  parameter int unsigned TOMAX   = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        regWrtm,
  input  logic        memWrtm,
  input  logic [1:0]  rsltSrcm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  input  logic [31:0] pc4m,
  input  logic [31:0] ujWrtBckm,
  input  logic [4:0]  rdm,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [31:0] dWdata,
  output logic [3:0]  dBe,
  input  logic        dAck,
  input  logic [31:0] dRdata,
  output logic        stallm,
  output logic        regWrtw,
  output logic [4:0]  rdw,
  output logic [31:0] rsltw,
  output logic        misalignw,
  output logic        busErrw
);

  state_e             state_q, state_d;
  logic [TOWIDTH-1:0] cnt_q, cnt_d;
  logic               regwrtw_q, regwrtw_d;
  logic [4:0]         rdw_q, rdw_d;
  logic [31:0]        rsltw_q, rsltw_d;
  logic               misalignw_q, misalignw_d;
  logic               buserrw_q, buserrw_d;

  logic        mem_op, misalign, req, stall, timeout;
  logic [31:0] ld_data, rslt_sel;

  assign mem_op = memWrtm | (rsltSrcm == RS_MEM);

  always_comb begin
    misalign = 1'b0;
    if ((funct3m == F3_H || funct3m == F3_HU) && aluRsltm[0])
      misalign = 1'b1;
    if (funct3m == F3_W && aluRsltm[1:0] != 2'b00)
      misalign = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          req = 1'b1;
          if (!dAck) begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (dAck) begin
          req     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TOWIDTH'(TOMAX)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence the bus and release the pipe without waiting for an edge.
  assign dReq   = rstn & req;
  assign stallm = rstn & stall;

  assign dAddr = {aluRsltm[31:2], 2'b00};
  assign dWe   = memWrtm;

  always_comb begin
    dBe    = 4'b1111;
    dWdata = wrtDm;
    case (funct3m[1:0])
      2'b00: begin
        dBe    = 4'b0001 << aluRsltm[1:0];
        dWdata = {4{wrtDm[7:0]}};
      end
      2'b01: begin
        dBe    = aluRsltm[1] ? 4'b1100 : 4'b0011;
        dWdata = {2{wrtDm[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata  (dRdata),
    .addr   (aluRsltm[1:0]),
    .funct3 (funct3m),
    .ld_data(ld_data)
  );

  always_comb begin
    case (rsltSrcm)
      RS_ALU:  rslt_sel = aluRsltm;
      RS_MEM:  rslt_sel = ld_data;
      RS_PC4:  rslt_sel = pc4m;
      default: rslt_sel = ujWrtBckm;
    endcase
  end

  always_comb begin
    regwrtw_d   = 1'b0;
    rdw_d       = rdw_q;
    rsltw_d     = rsltw_q;
    misalignw_d = 1'b0;
    buserrw_d   = 1'b0;
    if (stall) begin
      regwrtw_d = 1'b0;
    end else if (timeout) begin
      buserrw_d = 1'b1;
    end else if (mem_op && misalign) begin
      misalignw_d = 1'b1;
    end else begin
      regwrtw_d = regWrtm & ~memWrtm;
      rdw_d     = rdm;
      rsltw_d   = rslt_sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      regwrtw_q   <= 1'b0;
      rdw_q       <= '0;
      rsltw_q     <= '0;
      misalignw_q <= 1'b0;
      buserrw_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regwrtw_q   <= regwrtw_d;
      rdw_q       <= rdw_d;
      rsltw_q     <= rsltw_d;
      misalignw_q <= misalignw_d;
      buserrw_q   <= buserrw_d;
    end
  end

  assign regWrtw   = regwrtw_q;
  assign rdw       = rdw_q;
  assign rsltw     = rsltw_q;
  assign misalignw = misalignw_q;
  assign busErrw   = buserrw_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: transaction-level model predicts MEM/WB contents
// per cycle; bus-side outputs are checked mid-cycle by the driver.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TOMAX = 4;

  logic        clk, rstn;
  logic        regWrtm, memWrtm;
  logic [1:0]  rsltSrcm;
  logic [2:0]  funct3m;
  logic [31:0] aluRsltm, wrtDm, pc4m, ujWrtBckm;
  logic [4:0]  rdm;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWdata;
  logic [3:0]  dBe;
  logic        dAck;
  logic [31:0] dRdata;
  logic        stallm, regWrtw;
  logic [4:0]  rdw;
  logic [31:0] rsltw;
  logic        misalignw, busErrw;

  mem_stage #(.TOWIDTH(3), .TOMAX(TOMAX)) dut (
    .clk(clk), .rstn(rstn), .regWrtm(regWrtm), .memWrtm(memWrtm),
    .rsltSrcm(rsltSrcm), .funct3m(funct3m), .aluRsltm(aluRsltm), .wrtDm(wrtDm),
    .pc4m(pc4m), .ujWrtBckm(ujWrtBckm), .rdm(rdm), .dReq(dReq), .dWe(dWe),
    .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe), .dAck(dAck), .dRdata(dRdata),
    .stallm(stallm), .regWrtw(regWrtw), .rdw(rdw), .rsltw(rsltw),
    .misalignw(misalignw), .busErrw(busErrw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] r;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_rslt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] a,
                                           input logic [2:0] f3);
    longint      v;
    int unsigned sh;
    sh = 8 * a;
    case (f3)
      F3_B:    begin v = longint'((d >> sh) & 32'hFF);   if (v >= 128)   v -= 256;   end
      F3_BU:   v = longint'((d >> sh) & 32'hFF);
      F3_H:    begin v = longint'((d >> sh) & 32'hFFFF); if (v >= 32768) v -= 65536; end
      F3_HU:   v = longint'((d >> sh) & 32'hFFFF);
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && sb.size() > 0) begin
      e = sb.pop_front();
      chk("regWrtw", regWrtw, e.rw);
      chk("rdw", rdw, e.rd);
      chk("rsltw", rsltw, e.r);
      chk("misalignw", misalignw, e.mis);
      chk("busErrw", busErrw, e.berr);
    end
  end

  // lat: number of WAIT cycles before ack (0 = same cycle), negative = never acks.
  task automatic do_instr(input logic rw, input logic mw, input logic [1:0] src,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] pc4, input logic [31:0] uj, input logic [4:0] rd,
                          input int lat, input logic [31:0] rdat);
    bit          memop, mis, req, is_to, exp_req, exp_stall;
    int          ncyc;
    exp_t        e;
    logic [31:0] r, wd_e;
    logic [3:0]  be_e;
    memop = mw || (src == RS_MEM);
    mis   = ((f3 == F3_H || f3 == F3_HU) && addr[0]) || (f3 == F3_W && addr[1:0] != 2'b00);
    req   = memop && !mis;
    ncyc  = !req ? 1 : (lat < 0 ? TOMAX + 2 : lat + 1);
    case (f3)
      F3_B, F3_BU: begin be_e = 4'(32'd1 << addr[1:0]); wd_e = {24'b0, wd[7:0]} * 32'h01010101; end
      F3_H, F3_HU: begin be_e = 4'(32'd3 << addr[1:0]); wd_e = {16'b0, wd[15:0]} * 32'h00010001; end
      default:     begin be_e = 4'hF; wd_e = wd; end
    endcase
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #2;
      regWrtm = rw; memWrtm = mw; rsltSrcm = src; funct3m = f3; aluRsltm = addr;
      wrtDm = wd; pc4m = pc4; ujWrtBckm = uj; rdm = rd;
      dAck   = req ? (k == lat) : 1'($urandom);
      dRdata = (req && k == lat) ? rdat : $urandom;
      is_to  = req && lat < 0 && k == ncyc - 1;
      if (is_to)
        e = '{1'b0, m_rd, m_rslt, 1'b0, 1'b1};
      else if (req && k != lat)
        e = '{1'b0, m_rd, m_rslt, 1'b0, 1'b0};
      else if (memop && mis)
        e = '{1'b0, m_rd, m_rslt, 1'b1, 1'b0};
      else begin
        case (src)
          RS_ALU:  r = addr;
          RS_MEM:  r = ld_model(rdat, addr[1:0], f3);
          RS_PC4:  r = pc4;
          default: r = uj;
        endcase
        m_rd = rd; m_rslt = r;
        e = '{rw && !mw, rd, r, 1'b0, 1'b0};
      end
      sb.push_back(e);
      #3;
      exp_req   = req && !is_to;
      exp_stall = req && (lat < 0 ? (k < ncyc - 1) : (k < lat));
      chk("dReq", dReq, exp_req);
      chk("stallm", stallm, exp_stall);
      if (exp_req) begin
        chk("dAddr", dAddr, addr & 32'hFFFF_FFFC);
        chk("dWe", dWe, mw);
        chk("dBe", dBe, be_e);
        if (mw) chk("dWdata", dWdata, wd_e);
      end
    end
  endtask

  task automatic set_nop();
    regWrtm = 0; memWrtm = 0; rsltSrcm = RS_ALU; funct3m = 0; aluRsltm = 0;
    wrtDm = 0; pc4m = 0; ujWrtBckm = 0; rdm = 0; dAck = 0; dRdata = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int          kind, lat, sel;
    logic        rw, mw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] addr;

    rstn = 1'b0;
    set_nop();
    regWrtm = 1; rsltSrcm = RS_MEM; funct3m = F3_W; aluRsltm = 32'h100; rdm = 5'd1;
    #3;
    chk("rst_dReq", dReq, 0);
    chk("rst_stallm", stallm, 0);
    chk("rst_regWrtw", regWrtw, 0);
    chk("rst_rdw", rdw, 0);
    chk("rst_rsltw", rsltw, 0);
    chk("rst_misalignw", misalignw, 0);
    chk("rst_busErrw", busErrw, 0);
    repeat (2) @(posedge clk);
    #2;
    set_nop();
    rstn = 1'b1;
    mon_en = 1'b1;

    do_instr(1, 0, RS_MEM, F3_W,  32'h100, 0, 32'h4, 32'h8, 5'd3, 0, 32'hDEADBEEF);
    do_instr(1, 0, RS_MEM, F3_B,  32'h103, 0, 32'h4, 32'h8, 5'd4, 3, 32'h80FF0000);
    do_instr(1, 0, RS_MEM, F3_HU, 32'h102, 0, 32'h4, 32'h8, 5'd5, 1, 32'hBEEF1234);
    do_instr(0, 1, RS_ALU, F3_B,  32'h201, 32'hAB, 32'h4, 32'h8, 5'd6, 0, 32'h0);
    do_instr(1, 0, RS_MEM, F3_W,  32'h102, 0, 32'h4, 32'h8, 5'd7, 0, 32'h11111111);
    do_instr(1, 0, RS_MEM, F3_W,  32'h300, 0, 32'h4, 32'h8, 5'd8, -1, 32'h0);
    do_instr(1, 0, RS_PC4, F3_W,  32'h0, 0, 32'h1234, 32'h8, 5'd9, 0, 32'h0);
    do_instr(1, 0, RS_UJ,  F3_W,  32'h0, 0, 32'h4, 32'hCAFE0000, 5'd10, 0, 32'h0);

    // Pull reset while a load sits in WAIT.
    @(posedge clk);
    #2;
    set_nop();
    regWrtm = 1; rsltSrcm = RS_MEM; funct3m = F3_W; aluRsltm = 32'h400; rdm = 5'd11;
    sb.push_back('{1'b0, m_rd, m_rslt, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    chk("wait_stallm", stallm, 1);
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_dReq", dReq, 0);
    chk("midrst_stallm", stallm, 0);
    chk("midrst_regWrtw", regWrtw, 0);
    chk("midrst_rdw", rdw, 0);
    chk("midrst_rsltw", rsltw, 0);
    chk("midrst_busErrw", busErrw, 0);
    sb.delete();
    m_rd = '0;
    m_rslt = '0;
    @(posedge clk);
    #2;
    set_nop();
    rstn = 1'b1;
    mon_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom;
      if (kind <= 3) begin
        rw = 1'($urandom); mw = 0;
        sel = $urandom_range(0, 2);
        src = (sel == 0) ? RS_ALU : (sel == 1) ? RS_PC4 : RS_UJ;
        f3 = 3'($urandom);
      end else if (kind <= 7) begin
        rw = 1; mw = 0; src = RS_MEM;
        sel = $urandom_range(0, 4);
        f3 = (sel == 0) ? F3_B : (sel == 1) ? F3_H : (sel == 2) ? F3_W : (sel == 3) ? F3_BU : F3_HU;
      end else begin
        rw = 0; mw = 1; src = RS_ALU;
        sel = $urandom_range(0, 2);
        f3 = (sel == 0) ? F3_B : (sel == 1) ? F3_H : F3_W;
      end
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == F3_H || f3 == F3_HU) addr[0] = 1'b0;
        if (f3 == F3_W) addr[1:0] = 2'b00;
      end
      sel = $urandom_range(0, 11);
      lat = (sel == 11) ? -1 : sel % 4;
      do_instr(rw, mw, src, f3, addr, $urandom, $urandom, $urandom, 5'($urandom), lat, $urandom);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
